// File: rtl/uc_seq_pkg.sv
// Shared definitions for the uc_seq control unit: instruction encodings,
// sequencer states and the jump-condition evaluator.
package uc_pkg;

  localparam logic [15:0] OP_J    = 16'h0000;
  localparam logic [15:0] OP_JZ   = 16'h0001;
  localparam logic [15:0] OP_JNZ  = 16'h0002;
  localparam logic [15:0] OP_JA   = 16'h0003;
  localparam logic [15:0] OP_JAE  = 16'h0004;
  localparam logic [15:0] OP_JB   = 16'h0005;
  localparam logic [15:0] OP_CALL = 16'h0006;
  localparam logic [15:0] OP_RET  = 16'h0007;
  localparam logic [15:0] OP_EI   = 16'h0008;
  localparam logic [15:0] OP_DI   = 16'h0009;
  localparam logic [15:0] OP_RETI = 16'h000A;

  // IN = 0011_1000_0000_00pp, OUT/OUTI = 001?_0000_xxxx_xxxx
  localparam logic [15:0] IN_MASK   = 16'hFFFC;
  localparam logic [15:0] IN_MATCH  = 16'h3800;
  localparam logic [15:0] OUT_MASK  = 16'hEF00;
  localparam logic [15:0] OUT_MATCH = 16'h2000;

  typedef enum logic [1:0] {
    RUN,
    IO_WAIT,
    IRQ
  } state_t;

  function automatic logic cond_eval(input logic [2:0] cc, input logic z, input logic carry);
    logic taken;
    case (cc)
      3'd0:    taken = 1'b1;
      3'd1:    taken = z;
      3'd2:    taken = ~z;
      3'd3:    taken = ~carry & ~z;
      3'd4:    taken = ~carry;
      3'd5:    taken = carry;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/uc_seq_if.sv
// Instruction/flag inputs and control strobes between uc_seq and the datapath.
interface uc_seq_if #(
  parameter int PORT_W = 2
);
  logic [15:0]       opcode;
  logic              z;
  logic              carry;
  logic              io_ready;
  logic              irq;
  logic              s_inc;
  logic              push;
  logic              pop;
  logic              s_vec;
  logic              s_ent;
  logic              s_sal;
  logic              s_inm;
  logic              we3;
  logic              wez;
  logic [PORT_W-1:0] port;
  logic [2:0]        op_alu;
  logic              io_req;
  logic              irq_ack;
  logic              stack_err;
  logic              io_timeout;

  modport master (
    output opcode, z, carry, io_ready, irq,
    input  s_inc, push, pop, s_vec, s_ent, s_sal, s_inm, we3, wez,
           port, op_alu, io_req, irq_ack, stack_err, io_timeout
  );

  modport slave (
    input  opcode, z, carry, io_ready, irq,
    output s_inc, push, pop, s_vec, s_ent, s_sal, s_inm, we3, wez,
           port, op_alu, io_req, irq_ack, stack_err, io_timeout
  );
endinterface

// File: rtl/uc_seq_stack_track.sv
// PC-stack depth tracker: refuses pushes when full and pops when empty,
// flagging each refused request with a one-cycle err pulse.
module uc_stack_track #(
  parameter int STACK_DEPTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty,
  output logic full_nxt,
  output logic err
);
  localparam int DW = $clog2(STACK_DEPTH) + 1;
  localparam logic [DW-1:0] DMAX = DW'(STACK_DEPTH);

  logic [DW-1:0] depth;
  logic [DW-1:0] depth_nxt;

  assign full  = (depth == DMAX);
  assign empty = (depth == '0);

  always_comb begin
    depth_nxt = depth;
    err       = 1'b0;
    if (inc) begin
      if (full) err = 1'b1;
      else      depth_nxt = depth + DW'(1);
    end else if (dec) begin
      if (empty) err = 1'b1;
      else       depth_nxt = depth - DW'(1);
    end
  end

  // Lets the sequencer defer an interrupt that would overflow the stack.
  assign full_nxt = (depth_nxt == DMAX);

  always_ff @(posedge clk) begin
    if (reset) depth <= '0;
    else       depth <= depth_nxt;
  end
endmodule

// File: rtl/uc_seq.sv
// Stateful control unit: decodes the instruction word, sequences I/O waits
// and interrupt entry, and tracks call-stack depth.
module uc_seq
  import uc_pkg::*;
#(
  parameter int PORT_W      = 2,
  parameter int STACK_DEPTH = 8,
  parameter int IO_TIMEOUT  = 15
) (
  input logic   clk,
  input logic   reset,
  uc_seq_if.slave bus
);
  localparam logic [7:0] TIMEOUT_CNT = 8'(IO_TIMEOUT);

  state_t     state, state_nxt;
  logic       ie, ie_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       stack_err_q, io_timeout_q, timeout_set;

  logic s_inc, push, pop, s_vec, s_ent, s_sal, we3, wez, io_req, irq_ack;
  logic stk_inc, stk_dec, stk_full, stk_empty, stk_full_nxt, stk_err;

  logic [15:0] op;
  logic is_jump, is_call, is_ret, is_reti, is_ei, is_di, is_in, is_out, is_io;

  assign op      = bus.opcode;
  assign is_jump = (op[15:4] == 12'h000) && (op[3:0] <= 4'd5);
  assign is_call = (op == OP_CALL);
  assign is_ret  = (op == OP_RET);
  assign is_reti = (op == OP_RETI);
  assign is_ei   = (op == OP_EI);
  assign is_di   = (op == OP_DI);
  assign is_in   = ((op & IN_MASK) == IN_MATCH);
  assign is_out  = ((op & OUT_MASK) == OUT_MATCH);
  assign is_io   = is_in | is_out;

  // Kept apart from the main decode so the tracker's look-ahead can feed the irq gate.
  assign stk_inc = ~reset & (((state == RUN) & is_call) | (state == IRQ));
  assign stk_dec = ~reset & (state == RUN) & (is_ret | is_reti);

  uc_stack_track #(.STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clk     (clk),
    .reset   (reset),
    .inc     (stk_inc),
    .dec     (stk_dec),
    .full    (stk_full),
    .empty   (stk_empty),
    .full_nxt(stk_full_nxt),
    .err     (stk_err)
  );

  always_comb begin
    state_nxt    = state;
    ie_nxt       = ie;
    wait_cnt_nxt = wait_cnt;
    timeout_set  = 1'b0;
    s_inc        = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    s_vec        = 1'b0;
    s_ent        = 1'b0;
    s_sal        = 1'b0;
    we3          = 1'b0;
    wez          = 1'b0;
    io_req       = 1'b0;
    irq_ack      = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (is_io) begin
            io_req = 1'b1;
            if (bus.io_ready) begin
              s_inc = 1'b1;
              s_ent = is_in;
              we3   = is_in;
              s_sal = is_out;
            end else begin
              wait_cnt_nxt = 8'd1;
              state_nxt    = IO_WAIT;
            end
          end else if (is_jump) begin
            s_inc = ~cond_eval(op[2:0], bus.z, bus.carry);
          end else if (is_call) begin
            push  = ~stk_full;
            s_inc = stk_full;
          end else if (is_ret || is_reti) begin
            pop   = ~stk_empty;
            s_inc = stk_empty;
            if (is_reti) ie_nxt = 1'b1;
          end else if (is_ei) begin
            s_inc  = 1'b1;
            ie_nxt = 1'b1;
          end else if (is_di) begin
            s_inc  = 1'b1;
            ie_nxt = 1'b0;
          end else begin
            s_inc = 1'b1;
            we3   = op[11];
            wez   = op[11];
          end
          // Interrupts are taken only at a completed instruction with stack room left.
          if (bus.irq && ie && !stk_full_nxt && !(is_io && !bus.io_ready))
            state_nxt = IRQ;
        end
        IO_WAIT: begin
          io_req = 1'b1;
          if (bus.io_ready) begin
            s_inc     = 1'b1;
            s_ent     = is_in;
            we3       = is_in;
            s_sal     = is_out;
            state_nxt = RUN;
          end else if (wait_cnt >= TIMEOUT_CNT) begin
            s_inc       = 1'b1;
            timeout_set = 1'b1;
            state_nxt   = RUN;
          end else begin
            wait_cnt_nxt = wait_cnt + 8'd1;
          end
        end
        IRQ: begin
          push      = 1'b1;
          s_vec     = 1'b1;
          irq_ack   = 1'b1;
          ie_nxt    = 1'b0;
          state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      ie           <= 1'b0;
      wait_cnt     <= 8'd0;
      stack_err_q  <= 1'b0;
      io_timeout_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      ie           <= ie_nxt;
      wait_cnt     <= wait_cnt_nxt;
      stack_err_q  <= stack_err_q | stk_err;
      io_timeout_q <= io_timeout_q | timeout_set;
    end
  end

  assign bus.s_inc      = s_inc;
  assign bus.push       = push;
  assign bus.pop        = pop;
  assign bus.s_vec      = s_vec;
  assign bus.s_ent      = s_ent;
  assign bus.s_sal      = s_sal;
  assign bus.we3        = we3;
  assign bus.wez        = wez;
  assign bus.io_req     = io_req;
  assign bus.irq_ack    = irq_ack;
  assign bus.stack_err  = stack_err_q;
  assign bus.io_timeout = io_timeout_q;
  assign bus.s_inm      = op[12];
  assign bus.port       = op[PORT_W-1:0];
  assign bus.op_alu     = op[10:8];
endmodule

// File: tb/tb_uc_seq.sv
// Self-checking bench for uc_seq: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_uc_seq;
  localparam int DEPTH  = 2;
  localparam int IO_TMO = 4;

  localparam logic [11:0] B_INC  = 12'h800, B_PUSH = 12'h400, B_POP = 12'h200, B_VEC = 12'h100;
  localparam logic [11:0] B_ENT  = 12'h080, B_SAL  = 12'h040, B_WE3 = 12'h020, B_WEZ = 12'h010;
  localparam logic [11:0] B_REQ  = 12'h008, B_ACK  = 12'h004, B_SERR = 12'h002, B_TMO = 12'h001;

  localparam logic [15:0] C_CALL = 16'h0006, C_RET = 16'h0007, C_EI = 16'h0008, C_RETI = 16'h000A;
  localparam logic [15:0] ALU1 = 16'h4B12, ALU0 = 16'h5312, IN2 = 16'h3802, OUTP = 16'h2045;

  localparam int K_JMP = 0, K_CALL = 1, K_RET = 2, K_RETI = 3, K_EI = 4, K_DI = 5;
  localparam int K_IN = 6, K_OUT = 7, K_ALU = 8;

  typedef struct {
    logic [15:0] op;
    logic        z;
    logic        c;
    logic        rdy;
    logic [11:0] exp;
    string       name;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [15:0] cur_op;
  int          n_vec;
  int          n_bad;

  int   m_depth;
  int   m_waited;
  logic m_ie, m_vec, m_serr, m_tmo;

  uc_seq_if #(.PORT_W(2)) bus ();

  uc_seq #(.PORT_W(2), .STACK_DEPTH(DEPTH), .IO_TIMEOUT(IO_TMO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [15:0] op, input logic z, input logic c,
                               input logic rdy, input logic ir, input logic rst);
    @(negedge clk);
    reset        = rst;
    cur_op       = op;
    bus.opcode   = op;
    bus.z        = z;
    bus.carry    = c;
    bus.io_ready = rdy;
    bus.irq      = ir;
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [11:0] e);
    logic [17:0] want, got;
    want = {e[11:6], cur_op[12], e[5:4], cur_op[1:0], cur_op[10:8], e[3:0]};
    got  = {bus.s_inc, bus.push, bus.pop, bus.s_vec, bus.s_ent, bus.s_sal, bus.s_inm,
            bus.we3, bus.wez, bus.port, bus.op_alu, bus.io_req, bus.irq_ack,
            bus.stack_err, bus.io_timeout};
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("[TB] FAIL %s: got %05h want %05h (op %04h)", name, got, want, cur_op);
    end
  endtask

  task automatic step(input string name, input logic [15:0] op, input logic z, input logic c,
                      input logic rdy, input logic ir, input logic rst, input logic [11:0] e);
    applyStimulus(op, z, c, rdy, ir, rst);
    checkOutput(name, e);
  endtask

  function automatic int kindOf(input logic [15:0] op);
    if (op <= 16'd5)                             return K_JMP;
    if (op == 16'd6)                             return K_CALL;
    if (op == 16'd7)                             return K_RET;
    if (op == 16'd8)                             return K_EI;
    if (op == 16'd9)                             return K_DI;
    if (op == 16'd10)                            return K_RETI;
    if ((op >> 2) == 16'h0E00)                   return K_IN;
    if (op[15:13] == 3'b001 && op[11:8] == 4'h0) return K_OUT;
    return K_ALU;
  endfunction

  function automatic logic taken(input logic [15:0] op, input logic z, input logic c);
    case (op)
      16'h0000: return 1'b1;
      16'h0001: return z;
      16'h0002: return !z;
      16'h0003: return !(c || z);
      16'h0004: return !c;
      default:  return c;
    endcase
  endfunction

  function automatic logic [11:0] ioDone(input int k);
    return (k == K_IN) ? (B_INC | B_WE3 | B_ENT) : (B_INC | B_SAL);
  endfunction

  task automatic modelReset();
    m_depth = 0; m_waited = 0; m_ie = 1'b0; m_vec = 1'b0; m_serr = 1'b0; m_tmo = 1'b0;
  endtask

  // One instruction cycle of the behavioural model; returns the expected strobes.
  task automatic modelStep(input logic [15:0] op, input logic z, input logic c, input logic rdy,
                           input logic ir, input logic rst, output logic [11:0] e);
    int   k;
    logic ie_old, stall;
    e = 12'h000;
    if (m_serr) e = e | B_SERR;
    if (m_tmo)  e = e | B_TMO;
    if (rst) begin
      modelReset();
      return;
    end
    if (m_vec) begin
      e = e | B_PUSH | B_VEC | B_ACK;
      m_depth++;
      m_ie  = 1'b0;
      m_vec = 1'b0;
      return;
    end
    k = kindOf(op);
    if (m_waited > 0) begin
      e = e | B_REQ;
      if (rdy) begin
        e = e | ioDone(k);
        m_waited = 0;
      end else if (m_waited == IO_TMO) begin
        e = e | B_INC;
        m_tmo = 1'b1;
        m_waited = 0;
      end else begin
        m_waited++;
      end
      return;
    end
    ie_old = m_ie;
    stall  = 1'b0;
    case (k)
      K_JMP:  if (!taken(op, z, c)) e = e | B_INC;
      K_CALL: begin
        if (m_depth < DEPTH) begin e = e | B_PUSH; m_depth++; end
        else begin e = e | B_INC; m_serr = 1'b1; end
      end
      K_RET, K_RETI: begin
        if (m_depth > 0) begin e = e | B_POP; m_depth--; end
        else begin e = e | B_INC; m_serr = 1'b1; end
        if (k == K_RETI) m_ie = 1'b1;
      end
      K_EI: begin e = e | B_INC; m_ie = 1'b1; end
      K_DI: begin e = e | B_INC; m_ie = 1'b0; end
      K_IN, K_OUT: begin
        e = e | B_REQ;
        if (rdy) e = e | ioDone(k);
        else begin m_waited = 1; stall = 1'b1; end
      end
      default: begin
        e = e | B_INC;
        if (op[11]) e = e | B_WE3 | B_WEZ;
      end
    endcase
    if (ir && ie_old && !stall && m_depth < DEPTH) m_vec = 1'b1;
  endtask

  initial begin
    vec_t        tbl[$];
    logic [15:0] rop;
    logic [11:0] e;
    logic        rz, rc, rr, ri, rs;

    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    cur_op = 16'h0000;
    bus.opcode = 16'h0000; bus.z = 1'b0; bus.carry = 1'b0; bus.io_ready = 1'b0; bus.irq = 1'b0;
    applyStimulus(16'h0000, 0, 0, 0, 0, 1);
    applyStimulus(16'h0000, 0, 0, 0, 0, 1);

    step("reset_state", C_CALL, 0, 0, 1, 1, 1, 12'h000);

    tbl.push_back('{16'h0003, 1'b0, 1'b0, 1'b0, 12'h000,                         "ja_z0_c0"});
    tbl.push_back('{16'h0003, 1'b0, 1'b1, 1'b0, B_INC,                           "ja_c1"});
    tbl.push_back('{16'h0005, 1'b0, 1'b1, 1'b0, 12'h000,                         "jb_c1"});
    tbl.push_back('{16'h0002, 1'b1, 1'b0, 1'b0, B_INC,                           "jnz_z1"});
    tbl.push_back('{16'h0000, 1'b1, 1'b1, 1'b0, 12'h000,                         "j_always"});
    tbl.push_back('{16'h0001, 1'b0, 1'b0, 1'b0, B_INC,                           "jz_z0"});
    tbl.push_back('{16'h0001, 1'b1, 1'b0, 1'b0, 12'h000,                         "jz_z1"});
    tbl.push_back('{16'h0004, 1'b0, 1'b1, 1'b0, B_INC,                           "jae_c1"});
    tbl.push_back('{16'h0004, 1'b1, 1'b0, 1'b0, 12'h000,                         "jae_c0"});
    tbl.push_back('{ALU1,     1'b0, 1'b0, 1'b0, B_INC | B_WE3 | B_WEZ,           "alu_wr"});
    tbl.push_back('{ALU0,     1'b0, 1'b0, 1'b0, B_INC,                           "alu_nowr"});
    tbl.push_back('{IN2,      1'b0, 1'b0, 1'b1, B_INC | B_WE3 | B_ENT | B_REQ,   "in_ready"});
    tbl.push_back('{OUTP,     1'b0, 1'b0, 1'b1, B_INC | B_SAL | B_REQ,           "out_ready"});
    tbl.push_back('{16'h3077, 1'b0, 1'b0, 1'b1, B_INC | B_SAL | B_REQ,           "outi_ready"});
    tbl.push_back('{16'h0009, 1'b0, 1'b0, 1'b0, B_INC,                           "di"});
    tbl.push_back('{16'h000B, 1'b0, 1'b0, 1'b0, B_INC,                           "undef_alu"});
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].name, tbl[i].op, tbl[i].z, tbl[i].c, tbl[i].rdy, 1'b0, 1'b0, tbl[i].exp);

    step("call1", C_CALL, 0, 0, 0, 0, 0, B_PUSH);
    step("call2", C_CALL, 0, 0, 0, 0, 0, B_PUSH);
    step("call3_ovf", C_CALL, 0, 0, 0, 0, 0, B_INC);
    step("ret1", C_RET, 0, 0, 0, 0, 0, B_POP | B_SERR);
    step("ret2", C_RET, 0, 0, 0, 0, 0, B_POP | B_SERR);
    step("ret3_unf", C_RET, 0, 0, 0, 0, 0, B_INC | B_SERR);

    step("rst_b", ALU1, 0, 0, 0, 0, 1, B_SERR);
    step("in_w0", IN2, 0, 0, 0, 0, 0, B_REQ);
    step("in_w1", IN2, 0, 0, 0, 0, 0, B_REQ);
    step("in_w2", IN2, 0, 0, 0, 0, 0, B_REQ);
    step("in_done", IN2, 0, 0, 1, 0, 0, B_INC | B_WE3 | B_ENT | B_REQ);
    step("in_after", ALU0, 0, 0, 0, 0, 0, B_INC);

    step("out_w0", OUTP, 0, 0, 0, 0, 0, B_REQ);
    step("out_w1", OUTP, 0, 0, 0, 0, 0, B_REQ);
    step("out_w2", OUTP, 0, 0, 0, 0, 0, B_REQ);
    step("out_w3", OUTP, 0, 0, 0, 0, 0, B_REQ);
    step("out_tmo", OUTP, 0, 0, 0, 0, 0, B_INC | B_REQ);
    step("tmo_sticky", ALU0, 0, 0, 0, 0, 0, B_INC | B_TMO);

    step("ei", C_EI, 0, 0, 0, 0, 0, B_INC | B_TMO);
    step("irq_alu", ALU1, 0, 0, 0, 1, 0, B_INC | B_WE3 | B_WEZ | B_TMO);
    step("irq_enter", ALU1, 0, 0, 0, 1, 0, B_PUSH | B_VEC | B_ACK | B_TMO);
    step("irq_masked", ALU0, 0, 0, 0, 1, 0, B_INC | B_TMO);
    step("reti1", C_RETI, 0, 0, 0, 1, 0, B_POP | B_TMO);
    step("irq_again", ALU0, 0, 0, 0, 1, 0, B_INC | B_TMO);
    step("irq_enter2", ALU0, 0, 0, 0, 0, 0, B_PUSH | B_VEC | B_ACK | B_TMO);
    step("reti2", C_RETI, 0, 0, 0, 0, 0, B_POP | B_TMO);
    step("post_reti", ALU0, 0, 0, 0, 0, 0, B_INC | B_TMO);

    step("e_out0", OUTP, 0, 0, 0, 0, 0, B_REQ | B_TMO);
    step("e_out1", OUTP, 0, 0, 0, 0, 0, B_REQ | B_TMO);
    step("rst_in_wait", OUTP, 0, 0, 1, 0, 1, B_TMO);
    step("after_rst", ALU1, 0, 0, 0, 0, 0, B_INC | B_WE3 | B_WEZ);
    step("e_ei", C_EI, 0, 0, 0, 0, 0, B_INC);
    step("e_irq", ALU0, 0, 0, 0, 1, 0, B_INC);
    step("rst_in_irq", ALU0, 0, 0, 0, 1, 1, 12'h000);
    step("ie_cleared1", ALU0, 0, 0, 0, 1, 0, B_INC);
    step("ie_cleared2", ALU0, 0, 0, 0, 1, 0, B_INC);

    applyStimulus(ALU0, 0, 0, 0, 0, 1);
    modelReset();
    rop = ALU0;
    for (int i = 0; i < 800; i++) begin
      if (m_waited == 0) begin
        case ($urandom_range(0, 11))
          0:       rop = 16'($urandom_range(0, 5));
          1:       rop = C_CALL;
          2:       rop = C_RET;
          3:       rop = C_RETI;
          4:       rop = C_EI;
          5:       rop = 16'h0009;
          6:       rop = 16'h3800 | 16'($urandom_range(0, 3));
          7:       rop = 16'h2000 | 16'($urandom_range(0, 1) << 12) | 16'($urandom_range(0, 255));
          11:      rop = 16'($urandom);
          default: rop = 16'h4000 | 16'($urandom_range(0, 16'h1FFF));
        endcase
      end
      rz = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 3) == 0);
      ri = ($urandom_range(0, 2) == 0);
      rs = ($urandom_range(0, 79) == 0);
      applyStimulus(rop, rz, rc, rr, ri, rs);
      modelStep(rop, rz, rc, rr, ri, rs, e);
      checkOutput("random", e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/uc_seq.md
Name: uc_seq

Overview:
- Parametrised, stateful successor to the CPU's combinational control unit, decoding the same 16-bit instruction word.
- Adds carry-aware conditional jumps and call-stack depth tracking with overflow/underflow protection.
- Adds a ready/req handshake with timeout for IN/OUT ports, and a single maskable interrupt with EI/DI/RETI.
- Sits between the program ROM output and the datapath (PC mux, PC stack, register file, ALU, I/O muxes).

Parameters:
- PORT_W, 2, width of the port-select field (opcode[PORT_W-1:0]); 1..4.
- STACK_DEPTH, 8, number of PC-stack entries tracked; power of two, 2..64.
- IO_TIMEOUT, 15, max wait cycles for io_ready before abort; 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- opcode  in  16  current instruction word
- z  in  1  zero flag
- carry  in  1  carry flag
- io_ready  in  1  addressed port completes transfer this cycle
- irq  in  1  level interrupt request
- s_inc  out  1  1 = PC+1, 0 = jump target / stack / vector
- push  out  1  push PC+1 onto PC stack
- pop  out  1  pop PC from stack
- s_vec  out  1  PC source = interrupt vector
- s_ent  out  1  register write source = input port
- s_sal  out  1  output-port write strobe
- s_inm  out  1  opcode[12]
- we3  out  1  register-file write enable
- wez  out  1  flag write enable
- port  out  PORT_W  opcode[PORT_W-1:0]
- op_alu  out  3  opcode[10:8]
- io_req  out  1  I/O transfer requested
- irq_ack  out  1  one-cycle interrupt acknowledge
- stack_err  out  1  sticky stack over/underflow
- io_timeout  out  1  sticky I/O timeout

Behaviour:
- Encoding (decided):
  - J = 0x0000 (always taken). JZ = 0x0001 (taken if z). JNZ = 0x0002 (taken if !z).
  - JA = 0x0003 (taken if !carry & !z). JAE = 0x0004 (taken if !carry). JB = 0x0005 (taken if carry).
  - CALL = 0x0006. RET = 0x0007. EI = 0x0008. DI = 0x0009. RETI = 0x000A.
  - IN = 0011_1000_0000_00pp. OUT/OUTI = 001?_0000_xxxx_xxxx.
  - Any other opcode is ALU: s_inc = 1, we3 = wez = opcode[11].
- Taken jump: s_inc = 0. Untaken jump: s_inc = 1. Jumps write no registers.
- Reset: state RUN, ie = 0, depth = 0, wait counter = 0, stack_err = 0, io_timeout = 0. All strobes are 0 while reset is high.
- Strobe outputs are combinational from state and opcode. Pass-through fields (s_inm, port, op_alu) always follow opcode.
- States:
  - RUN → IO_WAIT: on IN/OUT with io_ready = 0.
  - RUN → IRQ: at an instruction boundary with irq & ie.
  - IO_WAIT → RUN: on io_ready = 1, or on timeout.
  - IRQ → RUN: always, after one cycle.
- IN/OUT in RUN:
  - io_req = 1.
  - If io_ready = 1: completes the same cycle. IN gives s_ent = 1, we3 = 1. OUT gives s_sal = 1. Both give s_inc = 1.
  - If io_ready = 0: s_inc = 0, we3 = 0, s_sal = 0, and the wait counter is loaded with 1.
- IO_WAIT:
  - io_req = 1. PC held (s_inc = 0, push = pop = 0).
  - Counter increments each cycle.
  - When io_ready = 1: complete as in RUN, go to RUN.
  - When counter = IO_TIMEOUT and io_ready = 0: set io_timeout, s_inc = 1, no write/strobe, go to RUN.
- Interrupt:
  - Sampled only in RUN when the current opcode is not IN/OUT waiting.
  - IRQ state for one cycle: push = 1, s_vec = 1, s_inc = 0, irq_ack = 1, ie ← 0. The current instruction is not executed; it re-executes after RETI.
  - If depth = STACK_DEPTH, the interrupt is deferred instead.
- Stack:
  - CALL: push = 1, depth+1.
  - RET and RETI: pop = 1, depth−1. RETI also sets ie ← 1.
  - CALL at depth = STACK_DEPTH: push suppressed, s_inc = 1, stack_err set.
  - RET/RETI at depth = 0: pop suppressed, s_inc = 1, stack_err set. RETI still sets ie.
- EI/DI take effect from the next cycle. EI followed by an immediately pending irq enters IRQ at the next boundary.
- Sticky flags clear only on reset.
- Reset mid-IO_WAIT or mid-IRQ returns to RUN the next cycle with no strobes.

Decomposition:
- Package uc_pkg holds:
  - opcode constants (OP_J..OP_RETI, IN/OUT match masks);
  - the state enum RUN/IO_WAIT/IRQ;
  - a condition-evaluation function taking (opcode[2:0], z, carry).
- One sub-module, uc_stack_track: depth counter with full/empty outputs and err pulse, parametrised by STACK_DEPTH.

Test Plan:
- Jumps: JA with z = 0, carry = 0 → s_inc = 0; with carry = 1 → s_inc = 1. JB with carry = 1 → s_inc = 0. JNZ with z = 1 → s_inc = 1.
- Stack overflow: STACK_DEPTH = 2; CALL, CALL, CALL → push = 1, 1, 0; stack_err = 1 after the third. Then RET ×3 → pop = 1, 1, 0.
- IN handshake: IN port 2 with io_ready low for 3 cycles then high → io_req = 1 for 4 cycles, s_inc = 0, 0, 0, 1, we3 and s_ent = 1 only in cycle 4, port = 2.
- I/O timeout: OUT with io_ready held 0, IO_TIMEOUT = 4 → io_timeout = 1 after the 4th wait cycle, s_inc = 1 that cycle, s_sal never 1.
- Interrupt: EI, then irq = 1 during an ALU op → next cycle irq_ack = 1, push = 1, s_vec = 1; a second irq is ignored until RETI (pop = 1, ie = 1).
- Reset: synchronous reset during IO_WAIT → all strobes 0 that cycle, state RUN after, stack_err/io_timeout = 0.
